serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal values are 2 to 64.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: operation request, sampled on each rising CLK edge.
REQ-005 The block SHALL have port Sub, input, 1 bit: 0 = A+B, 1 = A-B; sampled with Start.
REQ-006 The block SHALL have port A, input, WIDTH bits: first operand, sampled with Start.
REQ-007 The block SHALL have port B, input, WIDTH bits: second operand, sampled with Start.
REQ-008 The block SHALL have port Ready, output, 1 bit: high when the block is IDLE and can accept Start.
REQ-009 The block SHALL have port Done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port S, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port C, output, 1 bit: registered final carry-out.

Function
REQ-012 The block SHALL compute its result bit-serially, LSB first, through exactly one 1-bit full-adder cell (A, B, Cin to S, C) per cycle, with a 1-bit carry register between bits.
REQ-013 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-014 The block SHALL decode Ready as (state == IDLE) and Done as (state == DONE); both are purely state-decoded.
REQ-015 IDLE: a rising edge with Start=1 SHALL latch A, B and Sub into internal shift registers, clear the bit counter to 0, load the carry register with Sub, and move to RUN.
REQ-016 IDLE: a rising edge with Start=0 SHALL leave the state at IDLE.
REQ-017 RUN: each edge SHALL feed the operand-A LSB and the operand-B LSB (XOR Sub) plus the carry register into the cell.
REQ-018 RUN: on the same edge, the cell sum SHALL shift into the result shift register MSB side, the cell carry SHALL go to the carry register, both operand registers SHALL shift right by 1, and the counter SHALL increment.
REQ-019 RUN: on the edge that processes bit WIDTH-1, the block SHALL copy the full result to S and the final carry to C, and move to DONE.
REQ-020 RUN SHALL therefore last exactly WIDTH cycles.
REQ-021 DONE: the block SHALL hold for exactly one cycle and return to IDLE on the next edge.
REQ-022 Latency: if Start is accepted at edge E0, Done SHALL be high from edge E(WIDTH) to edge E(WIDTH+1), and Ready SHALL be high again after E(WIDTH+1).
REQ-023 Start SHALL be ignored while in RUN or DONE; the in-flight operation and the latched operands SHALL be unaffected.
REQ-024 Changes on A, B or Sub after acceptance SHALL have no effect.
REQ-025 S and C SHALL change only on entry to DONE or on reset, and SHALL hold their values across IDLE and across subsequent RUN periods until the next DONE.
REQ-026 Arithmetic: S SHALL equal (A + B) mod 2^WIDTH with C = carry out of bit WIDTH-1.
REQ-027 For subtraction, S SHALL equal (A - B) mod 2^WIDTH with C = 1 when A >= B (no borrow) and C = 0 otherwise (unsigned).
REQ-028 Back-to-back operation: Start held high continuously SHALL yield one accepted operation every WIDTH+2 cycles.

Reset
REQ-029 While RST=1, independent of CLK, the block SHALL force: state=IDLE, Ready=1, Done=0, S=0, C=0, counter=0, carry register=0, and operand/result shift registers=0.
REQ-030 RST asserted during RUN or DONE SHALL abort the operation with no Done pulse; after RST is released the block SHALL accept Start on the first rising edge.

Verification
REQ-031 The bench SHALL cover these directed scenarios, with WIDTH=8:
- Add: A=0x3C, B=0x5A, Sub=0 -> S=0x96, C=0, with Done exactly 8 edges after acceptance and 1 cycle wide.
- Add with wrap: A=0xFF, B=0x01, Sub=0 -> S=0x00, C=1.
- Subtract without borrow: A=0x10, B=0x01, Sub=1 -> S=0x0F, C=1.
- Subtract with borrow: A=0x01, B=0x02, Sub=1 -> S=0xFF, C=0.
- Start pulsed mid-RUN with different A/B -> ignored; first result unchanged; only one Done.
- RST pulsed at bit 4 of A=0xAA+B=0x55 -> no Done, S=0x00, C=0, Ready=1; a new Start then completes normally.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell per cycle, LSB first,
// with an IDLE/RUN/DONE controller and registered result and carry-out.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sub;
    logic [WIDTH-1:0] r_s;
    logic             r_c;

    logic             w_a;
    logic             w_b;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;

    // Single full-adder cell; B is inverted for subtraction, carry-in preloaded with Sub.
    assign w_a    = r_a[0];
    assign w_b    = r_b[0] ^ r_sub;
    assign w_sum  = w_a ^ w_b ^ r_carry;
    assign w_cout = (w_a & w_b) | (r_carry & (w_a ^ w_b));
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    assign Ready = (r_state == IDLE);
    assign Done  = (r_state == DONE);
    assign S     = r_s;
    assign C     = r_c;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_s     <= '0;
            r_c     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sub   <= Sub;
                        r_carry <= Sub;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Sum enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s     <= {w_sum, r_res[WIDTH-1:1]};
                        r_c     <= w_cout;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, random ops,
// and directed sequences for mid-run Start, back-to-back and reset abort.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic         Sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ready;
    logic         Done;
    logic [W-1:0] S;
    logic         C;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .Ready (Ready),
        .Done  (Done),
        .S     (S),
        .C     (C)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    int           total = 0;
    int           bad = 0;
    int           done_cnt = 0;
    logic [W:0]   sb_q[$];
    logic [W-1:0] prev_s = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard: every Done pops the oldest expected {C,S}.
    always @(negedge CLK) begin
        if (!RST && Done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'(done_cnt), 64'(0));
            end else begin
                logic [W:0] e;
                e = sb_q.pop_front();
                chk("result_s", 64'(S), 64'(e[W-1:0]));
                chk("result_c", 64'(C), 64'(e[W]));
            end
        end
    end

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0] r;
        if (sub) r = {(a >= b), W'(a - b)};
        else     r = (W+1)'(a) + (W+1)'(b);
        return r;
    endfunction

    // Issue one op from a negedge with Ready high; ends on a negedge with Ready high again.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] es, input logic ec);
        int k;
        int d0;
        chk("ready_before", 64'(Ready), 64'(1));
        A = a; B = b; Sub = sub; Start = 1'b1;
        sb_q.push_back({ec, es});
        @(negedge CLK);
        Start = 1'b0;
        A = W'($urandom); B = W'($urandom); Sub = 1'($urandom);
        d0 = done_cnt;
        k = 0;
        while (!Done && k < 4 * W) begin
            @(negedge CLK);
            k++;
            if (k == 2) chk("s_hold", 64'(S), 64'(prev_s));
        end
        chk("latency", 64'(k), 64'(W));
        @(negedge CLK);
        chk("done_width", 64'(Done), 64'(0));
        chk("ready_after", 64'(Ready), 64'(1));
        chk("one_done", 64'(done_cnt - d0), 64'(1));
        prev_s = es;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!Done && k < 4 * W);
    endtask

    initial begin
        vec_t vecs[9];
        logic [W:0] m;
        int k1;
        int k2;
        int d0;

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
        vecs[3] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        RST = 1'b1; Start = 1'b0; Sub = 1'b0; A = '0; B = '0;
        #12;
        chk("rst_ready", 64'(Ready), 64'(1));
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_s", 64'(S), 64'(0));
        chk("rst_c", 64'(C), 64'(0));
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].es, vecs[i].ec);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            m = model(ra, rb, rs);
            do_op(ra, rb, rs, m[W-1:0], m[W]);
        end

        // Start pulsed mid-RUN with different operands must be ignored.
        d0 = done_cnt;
        A = 8'h3C; B = 8'h5A; Sub = 1'b0; Start = 1'b1;
        sb_q.push_back({1'b0, 8'h96});
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        A = 8'h11; B = 8'h22; Sub = 1'b1; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        wait_done(k1);
        chk("midrun_latency", 64'(k1 + 4), 64'(W));
        repeat (2 * W) @(negedge CLK);
        chk("midrun_one_done", 64'(done_cnt - d0), 64'(1));
        chk("midrun_s", 64'(S), 64'(8'h96));
        prev_s = 8'h96;

        // Start held high: accepted every W+2 cycles.
        d0 = done_cnt;
        A = 8'h21; B = 8'h43; Sub = 1'b0; Start = 1'b1;
        sb_q.push_back({1'b0, 8'h64});
        sb_q.push_back({1'b0, 8'h64});
        wait_done(k1);
        wait_done(k2);
        Start = 1'b0;
        chk("b2b_first", 64'(k1), 64'(W + 1));
        chk("b2b_period", 64'(k2), 64'(W + 2));
        repeat (2) @(negedge CLK);
        chk("b2b_count", 64'(done_cnt - d0), 64'(2));
        prev_s = 8'h64;

        // Reset during RUN aborts with no Done and clears outputs.
        d0 = done_cnt;
        A = 8'hAA; B = 8'h55; Sub = 1'b0; Start = 1'b1;
        sb_q.push_back({1'b0, 8'hFF});
        @(negedge CLK);
        Start = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("abort_ready", 64'(Ready), 64'(1));
        chk("abort_done", 64'(Done), 64'(0));
        chk("abort_s", 64'(S), 64'(0));
        chk("abort_c", 64'(C), 64'(0));
        sb_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        prev_s = '0;
        do_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);

        repeat (3) @(negedge CLK);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
